// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch state encoding, fault codes
// and PC stepping constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_FAULT  = 3'd5
    } fetch_state_t;

    localparam logic [1:0]  FLT_NONE    = 2'd0;
    localparam logic [1:0]  FLT_ODDPC   = 2'd1;
    localparam logic [1:0]  FLT_TIMEOUT = 2'd2;

    localparam logic [15:0] PC_STEP          = 16'd2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Program memory read port: the fetch stage drives address and request,
// memory answers with ready and data.
interface instruction_fetch_if;

    logic [15:0] MAR;
    logic        MemRd;
    logic        MemRdy;
    logic [15:0] MemData;

    modport master (output MAR, MemRd, input MemRdy, MemData);
    modport slave  (input MAR, MemRd, output MemRdy, MemData);

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts WAIT cycles without MemRdy; tc flags the cycle that would be the
// MEM_TIMEOUT-th such cycle.
module fetch_timeout_counter #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic Clock,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VALUE = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per instruction and
// hands it to the decoder with a single-cycle E strobe.
//
// state  | meaning
// IDLE   | parked, waiting for Run
// FETCH  | check PC alignment, launch the memory read
// WAIT   | read outstanding, watching MemRdy and the timeout
// DECODE | E high for one cycle, PC advances
// EXEC   | instruction in flight, waiting for ExDone / PCLd
// FAULT  | parked on odd PC or timeout until an even PCLd
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic                       Clock,
    input  logic                       nReset,
    input  logic                       Run,
    input  logic                       ExDone,
    input  logic                       PCLd,
    input  logic [15:0]                PCNew,
    instruction_fetch_if.master        mem,
    output logic [15:0]                Instr,
    output logic                       E,
    output logic [15:0]                PC,
    output logic                       FLT,
    output logic [1:0]                 FltCode
);

    fetch_state_t state, state_nxt;

    logic [15:0] pc_q, pc_nxt;
    logic [15:0] mar_q, mar_nxt;
    logic [15:0] instr_q, instr_nxt;
    logic        rd_q, rd_nxt;
    logic        e_q, e_nxt;
    logic        flt_q, flt_nxt;
    logic [1:0]  code_q, code_nxt;
    logic        tmo_clr, tmo_en, tmo_tc;

    fetch_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .Clock  (Clock),
        .nReset (nReset),
        .clear  (tmo_clr),
        .enable (tmo_en),
        .tc     (tmo_tc)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            mar_q   <= RESET_PC;
            instr_q <= 16'h0000;
            rd_q    <= 1'b0;
            e_q     <= 1'b0;
            flt_q   <= 1'b0;
            code_q  <= FLT_NONE;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            mar_q   <= mar_nxt;
            instr_q <= instr_nxt;
            rd_q    <= rd_nxt;
            e_q     <= e_nxt;
            flt_q   <= flt_nxt;
            code_q  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        mar_nxt   = mar_q;
        instr_nxt = instr_q;
        rd_nxt    = rd_q;
        e_nxt     = 1'b0;
        flt_nxt   = flt_q;
        code_nxt  = code_q;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (pc_q[0]) begin
                    flt_nxt   = 1'b1;
                    code_nxt  = FLT_ODDPC;
                    state_nxt = ST_FAULT;
                end else begin
                    mar_nxt   = pc_q;
                    rd_nxt    = 1'b1;
                    tmo_clr   = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Data arriving on the terminal cycle beats the timeout.
                if (mem.MemRdy) begin
                    instr_nxt = mem.MemData;
                    rd_nxt    = 1'b0;
                    e_nxt     = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (tmo_tc) begin
                    rd_nxt    = 1'b0;
                    flt_nxt   = 1'b1;
                    code_nxt  = FLT_TIMEOUT;
                    state_nxt = ST_FAULT;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ST_DECODE: begin
                pc_nxt    = pc_q + PC_STEP;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (PCLd)   pc_nxt    = PCNew;
                if (ExDone) state_nxt = Run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                rd_nxt = 1'b0;
                if (PCLd && !PCNew[0]) begin
                    pc_nxt    = PCNew;
                    flt_nxt   = 1'b0;
                    code_nxt  = FLT_NONE;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem.MAR   = mar_q;
    assign mem.MemRd = rd_q;
    assign Instr     = instr_q;
    assign E         = e_q;
    assign PC        = pc_q;
    assign FLT       = flt_q;
    assign FltCode   = code_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the basic CPU: holds the program counter, reads one 16-bit instruction word per instruction from program memory over a ready/valid-style handshake, and presents it on `Instr` together with a one-cycle `E` strobe that drives the `instruction_decoder` directly downstream. It then holds until the execute stage reports completion or a PC load, enforcing one instruction in flight. Misaligned PCs and memory timeouts raise a fault and park the stage.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `MEM_TIMEOUT`, 15: max cycles waited for `MemRdy` before fault; legal range 1–255.
- `Clock`  in  1  system clock; all state changes on rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Run`  in  1  level; 1 allows fetching, 0 parks the stage in IDLE after the current instruction.
- `ExDone`  in  1  one-cycle pulse from execute: current instruction finished.
- `PCLd`  in  1  one-cycle pulse from execute: load `PCNew` (branch/jump/trap).
- `PCNew`  in  16  new PC value, valid with `PCLd`.
- `MemRdy`  in  1  program memory: `MemData` valid this cycle.
- `MemData`  in  16  program memory read data.
- `MAR`  out  16  program memory byte address.
- `MemRd`  out  1  read request, level, held until `MemRdy`.
- `Instr`  out  16  latched instruction word for the decoder.
- `E`  out  1  decoder enable, one-cycle pulse.
- `PC`  out  16  architectural PC (already advanced past `Instr` once `E` fires).
- `FLT`  out  1  fault flag, level.
- `FltCode`  out  2  0 none, 1 odd PC, 2 memory timeout.

## Operation
- States: IDLE, FETCH, WAIT, DECODE, EXEC, FAULT. Reset state IDLE.
- IDLE: `Run`=1 → FETCH, else stay.
- FETCH: if `PC[0]`=1 → FAULT, code 1, no read issued; else `MAR`←`PC`, `MemRd`←1, timeout counter←0, → WAIT.
- WAIT: `MemRdy`=1 → `Instr`←`MemData`, `MemRd`←0, → DECODE. Else counter+1; counter reaching `MEM_TIMEOUT` → `MemRd`←0, FAULT, code 2.
- DECODE: `E`=1 for this cycle only; `PC`←`PC`+2 (16-bit wrap, 16'hFFFE+2 = 16'h0000); → EXEC.
- EXEC: `PCLd`=1 → `PC`←`PCNew`. `ExDone`=1 → FETCH if `Run`=1, else IDLE. `PCLd` and `ExDone` in same cycle: load applies, then transition. `PCLd` without `ExDone`: load applies, stay in EXEC.
- FAULT: `FLT`=1, `MemRd`=0. `PCLd` with `PCNew[0]`=0 → `PC`←`PCNew`, clear `FLT`/`FltCode`, → IDLE. `PCLd` with odd `PCNew` ignored. Otherwise exit only by reset.
- `PCLd`/`ExDone` outside EXEC/FAULT are ignored (no instruction executing).
- `Run` deasserted mid-fetch does not abort: fetch completes, `E` fires, the instruction executes, then IDLE.
- `Instr` changes only on WAIT→DECODE; stable throughout DECODE and EXEC.

## Timing
- Reset values: `PC`=`RESET_PC`, `MAR`=`RESET_PC`, `Instr`=16'h0000, `MemRd`=0, `E`=0, `FLT`=0, `FltCode`=0, counter=0.
- `nReset` low at any time (mid-WAIT included) clears all state immediately and drops `MemRd` asynchronously.
- `MemRd` and `MAR` are registered outputs, valid from the cycle after FETCH.
- Minimum latency: FETCH entry to `E` high = 2 cycles with `MemRdy` in the first WAIT cycle; each extra wait cycle adds 1.
- Best-case throughput with `ExDone` in the first EXEC cycle: one instruction per 4 cycles.
- `E` is a registered, glitch-free pulse.
- Timeout fires on the `MEM_TIMEOUT`-th WAIT cycle without `MemRdy`; `MemRdy` in that same cycle wins (data accepted, no fault).

## Structure
- Shared package `cpu_pkg`: state encoding enum, `FLT_NONE/FLT_ODDPC/FLT_TIMEOUT` codes, `PC_STEP`=2, default `RESET_PC`.
- One sub-module: `fetch_timeout_counter` (clear, enable, terminal-count output parameterised by `MEM_TIMEOUT`).

## Test plan
- Reset, `Run`=1, `MemRdy` in first WAIT cycle, `MemData`=16'h4C9A -> `MAR`=0000, `E` pulses 2 cycles after FETCH, `Instr`=4C9A, `PC`=0002.
- `MemRdy` delayed 3 cycles, then `ExDone` -> `E` 5 cycles after FETCH; next `MAR`=0002.
- In EXEC, `PCLd`+`ExDone` same cycle, `PCNew`=16'h1234 -> next `MAR`=1234; `PC`=1236 after `E`.
- `PCNew`=16'h0101 -> `FLT`=1, `FltCode`=1, `MemRd` never asserted; then `PCLd` `PCNew`=0200 -> `FLT`=0, IDLE, next fetch at 0200.
- `MemRdy` held low with `MEM_TIMEOUT`=15 -> `FLT`=1, `FltCode`=2 after 15 WAIT cycles, `MemRd`=0, no `E`.
- `nReset` pulsed low during WAIT -> `MemRd`=0 immediately, `PC`=`RESET_PC`, `E` never fires for the aborted fetch; `PC`=16'hFFFE fetch -> `PC`=0000 after `E`.
